// File: rtl/priority_encoder_pipe.sv
// Registered priority encoder with a 2-entry output FIFO and valid/ready on both sides.
// Latency 1 cycle when empty; full throughput under backpressure. Multi-hot checker under `ONEHOT_CHECK_EN.
// in_ready drops only when both buffer entries are occupied (or during reset); out_valid is purely registered.
module priority_encoder_pipe #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0,
   parameter int ERR_CNT_W = 8,
   localparam int CODE_W   = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CODE_W-1:0]    out_code,
   output logic                 out_none,
   output logic                 out_multi,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t              state, state_nxt;
   logic                push, pop;
   logic                ld_head_new, ld_head_tail, ld_tail;
   logic [CODE_W-1:0]   enc_code;
   logic                enc_none;
   logic [CODE_W-1:0]   head_code, tail_code;
   logic                head_none, tail_none;

   assign in_ready  = rst_n && (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Scan order makes the last match the winner, so no priority chain is needed.
   always_comb begin
      enc_code = '0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++)
            if (in_data[i]) enc_code = CODE_W'(i);
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (in_data[i]) enc_code = CODE_W'(i);
      end
   end

   assign enc_none = (in_data == '0);

   always_comb begin
      state_nxt    = state;
      ld_head_new  = 1'b0;
      ld_head_tail = 1'b0;
      ld_tail      = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt   = ONE;
               ld_head_new = 1'b1;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_nxt = FULL;
               ld_tail   = 1'b1;
            end else if (push && pop) begin
               ld_head_new = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt    = ONE;
               ld_head_tail = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         head_code <= '0;
         head_none <= 1'b0;
         tail_code <= '0;
         tail_none <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ld_head_new) begin
            head_code <= enc_code;
            head_none <= enc_none;
         end else if (ld_head_tail) begin
            head_code <= tail_code;
            head_none <= tail_none;
         end
         if (ld_tail) begin
            tail_code <= enc_code;
            tail_none <= enc_none;
         end
      end
   end

   assign out_code = head_code;
   assign out_none = head_none;

`ifdef ONEHOT_CHECK_EN
   logic                 enc_multi;
   logic                 head_multi, tail_multi;
   logic [ERR_CNT_W-1:0] err_cnt;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign enc_multi = |(in_data & (in_data - WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_multi <= 1'b0;
         tail_multi <= 1'b0;
         err_cnt    <= '0;
      end else begin
         if (ld_head_new)       head_multi <= enc_multi;
         else if (ld_head_tail) head_multi <= tail_multi;
         if (ld_tail)           tail_multi <= enc_multi;
         if (push && enc_multi && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

   assign out_multi = head_multi;
   assign err_count = err_cnt;
`else
   assign out_multi = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Directed and randomized checks of priority_encoder_pipe against a behavioural model.
module tb_priority_encoder_pipe;

`ifdef ONEHOT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int N_RAND = 10000;
   localparam int LIMIT  = 60000;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, lowest bit wins, 2-bit error counter.
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_in_data;
   logic [2:0] a_out_code;
   logic       a_out_none, a_out_multi;
   logic [1:0] a_err;

   // Instance B: WIDTH=5, highest bit wins.
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [4:0] b_in_data;
   logic [2:0] b_out_code;
   logic       b_out_none, b_out_multi;
   logic [7:0] b_err;

   priority_encoder_pipe #(.WIDTH(8), .MSB_FIRST(0), .ERR_CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_code(a_out_code), .out_none(a_out_none), .out_multi(a_out_multi),
      .err_count(a_err));

   priority_encoder_pipe #(.WIDTH(5), .MSB_FIRST(1), .ERR_CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_code(b_out_code), .out_none(b_out_none), .out_multi(b_out_multi),
      .err_count(b_err));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int log2_floor(input int v);
      int k = 0;
      while (v > 1) begin
         v = v >> 1;
         k++;
      end
      return k;
   endfunction

   function automatic int ref_word(input int v, input bit msb_first);
      int code, none, multi;
      none  = (v == 0) ? 1 : 0;
      if (v == 0)         code = 0;
      else if (msb_first) code = log2_floor(v);
      else                code = log2_floor(v & -v);
      multi = (CHK && $countones(v) >= 2) ? 1 : 0;
      return code | (none << 8) | (multi << 9);
   endfunction

   function automatic logic [31:0] a_obs();
      return 32'(a_out_code) | (32'(a_out_none) << 8) | (32'(a_out_multi) << 9);
   endfunction

   function automatic logic [31:0] b_obs();
      return 32'(b_out_code) | (32'(b_out_none) << 8) | (32'(b_out_multi) << 9);
   endfunction

   int a_err_model = 0;
   int b_err_model = 0;
   int q[$];

   initial begin
      int exp_w, cyc, words_in, words_out;
      bit b_hold;

      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_a_out_valid", 32'(a_out_valid), 0);
      chk("rst_a_in_ready", 32'(a_in_ready), 0);
      chk("rst_a_fields", a_obs(), 0);
      chk("rst_a_err", 32'(a_err), 0);
      chk("rst_b_out_valid", 32'(b_out_valid), 0);
      chk("rst_b_fields", b_obs(), 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_a_in_ready", 32'(a_in_ready), 1);

      // T1: walking one, streaming
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 8'(1 << i);
         #1 chk("t1_in_ready", 32'(a_in_ready), 1);
         @(negedge clk);
         chk("t1_out_valid", 32'(a_out_valid), 1);
         chk("t1_word", a_obs(), 32'(ref_word(1 << i, 1'b0)));
      end
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("t1_drained", 32'(a_out_valid), 0);

      // T2: zero vector and multi-hot vector
      a_in_valid = 1'b1; a_in_data = 8'h00;
      @(negedge clk);
      chk("t2_zero", a_obs(), 32'h100);
      a_in_data = 8'h28;
      @(negedge clk);
      chk("t2_28_code", 32'(a_out_code), 3);
      chk("t2_28_multi", 32'(a_out_multi), 32'(CHK));
      if (CHK) a_err_model++;
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("t2_err", 32'(a_err), 32'(a_err_model));

      // T3: backpressure fills buffer, then drain in order
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 8'h02;
      @(negedge clk);
      chk("t3_ready_one", 32'(a_in_ready), 1);
      chk("t3_head1", a_obs(), 1);
      a_in_data = 8'h04;
      @(negedge clk);
      chk("t3_ready_full", 32'(a_in_ready), 0);
      chk("t3_stable1", a_obs(), 1);
      a_in_data = 8'h08;
      @(negedge clk);
      chk("t3_still_full", 32'(a_in_ready), 0);
      chk("t3_stable2", a_obs(), 1);
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("t3_second", a_obs(), 2);
      @(negedge clk);
      chk("t3_third", a_obs(), 3);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("t3_empty", 32'(a_out_valid), 0);

      // T4: reset while full
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 8'h10;
      repeat (2) @(negedge clk);
      chk("t4_full", 32'(a_in_ready), 0);
      rst_n = 1'b0; a_out_ready = 1'b1;
      #1 chk("t4_ready_in_rst", 32'(a_in_ready), 0);
      @(negedge clk);
      chk("t4_valid_rst", 32'(a_out_valid), 0);
      chk("t4_err_rst", 32'(a_err), 0);
      a_err_model = 0;
      rst_n = 1'b1; a_in_valid = 1'b0;
      #1 chk("t4_ready_after", 32'(a_in_ready), 1);
      @(negedge clk);
      chk("t4_no_stale", 32'(a_out_valid), 0);

      // T5: saturating multi-hot counter
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'hC0;
         @(negedge clk);
         if (CHK && a_err_model < 3) a_err_model++;
         chk("t5_word", a_obs(), 32'(ref_word(8'hC0, 1'b0)));
         chk("t5_err", 32'(a_err), 32'(a_err_model));
      end
      a_in_valid = 1'b0;

      // T6: random traffic on the 5-bit instance
      cyc = 0; words_in = 0; words_out = 0; b_hold = 1'b0;
      while (words_out < N_RAND && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         if (!b_hold) begin
            b_in_valid = (words_in < N_RAND) && ($urandom_range(3) != 0);
            b_in_data  = 5'($urandom_range(31));
         end
         b_out_ready = ($urandom_range(3) != 0);
         #1;
         if (b_out_valid && b_out_ready) begin
            if (q.size() == 0) begin
               chk("t6_spurious", 32'(b_out_valid), 0);
            end else begin
               exp_w = q.pop_front();
               chk("t6_word", b_obs(), 32'(exp_w));
            end
            words_out++;
         end
         if (b_in_valid && b_in_ready) begin
            q.push_back(ref_word(int'(b_in_data), 1'b1));
            if (CHK && $countones(b_in_data) >= 2 && b_err_model < 255) b_err_model++;
            words_in++;
            b_hold = 1'b0;
         end else begin
            b_hold = b_in_valid;
         end
      end
      b_in_valid = 1'b0;
      chk("t6_budget", 32'(words_out), 32'(N_RAND));
      chk("t6_leftover", 32'(q.size()), 0);
      @(negedge clk);
      chk("t6_err", 32'(b_err), 32'(b_err_model));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
